stopwatch_ctrl: RTL and testbench

//   Front-panel sequencer for the 00-99 stopwatch counter. Synchronises and debounces
//   two raw push-buttons (start/stop, lap/reset) and runs a 4-state FSM that drives
//   the counter's go/clr inputs. Captures a lap value and selects live or lap count
//   for the display path. Sits between board buttons and counter + 7-seg driver in top level.

---
 rtl/stopwatch_ctrl.sv | 148 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel sequencer: 2-FF sync + debounce on two buttons, IDLE/RUN/PAUSE/LAP FSM.
// Define AUTO_STOP_EN to pause automatically at terminal count instead of wrapping.
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int CNT_MAX    = 99
) (
    input  logic                             clk,
    input  logic                             clr_n,
    input  logic                             btn_ss,
    input  logic                             btn_lr,
    input  logic [$clog2(CNT_MAX + 1)-1:0]   cnt_val,
    output logic                             cnt_go,
    output logic                             cnt_clr,
    output logic [$clog2(CNT_MAX + 1)-1:0]   disp_val,
    output logic                             lap_active,
    output logic [1:0]                       state_o
);

    localparam int VAL_W = $clog2(CNT_MAX + 1);
    localparam int DW    = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    state_t           state;
    logic [VAL_W-1:0] lap_val;

    // Bit 0 is start/stop, bit 1 is lap/reset throughout the input path.
    logic [1:0]    raw;
    logic [1:0]    sync_p0;
    logic [1:0]    sync_p1;
    logic [1:0]    level;
    logic [1:0]    press;
    logic [DW-1:0] deb_cnt [2];
    logic          ss_p;
    logic          lr_p;
    logic          at_max;

    assign raw     = {btn_lr, btn_ss};
    assign ss_p    = press[0];
    assign lr_p    = press[1];
    assign state_o = state;

`ifdef AUTO_STOP_EN
    assign at_max = (cnt_val == VAL_W'(CNT_MAX));
`else
    assign at_max = 1'b0;
`endif

    // Stage p0/p1: synchroniser; then debounce against the accepted level.
    // Any return to the accepted level restarts the count, so a press needs
    // DEB_CYCLES consecutive clocks of the new level.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_p0    <= '0;
            sync_p1    <= '0;
            level      <= '0;
            press      <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync_p1[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    deb_cnt[i] <= '0;
                    level[i]   <= sync_p1[i];
                    press[i]   <= sync_p1[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Sequencer: outputs are written alongside each transition so they are registered.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            cnt_go     <= 1'b0;
            cnt_clr    <= 1'b0;
            disp_val   <= '0;
            lap_active <= 1'b0;
            lap_val    <= '0;
        end else begin
            cnt_clr  <= 1'b0;
            disp_val <= (state == LAP) ? lap_val : cnt_val;
            case (state)
                IDLE: begin
                    if (ss_p) begin
                        state  <= RUN;
                        cnt_go <= 1'b1;
                    end else if (lr_p) begin
                        cnt_clr <= 1'b1;
                    end
                end
                RUN: begin
                    if (at_max) begin
                        state  <= PAUSE;
                        cnt_go <= 1'b0;
                    end else if (ss_p) begin
                        state  <= PAUSE;
                        cnt_go <= 1'b0;
                    end else if (lr_p) begin
                        state      <= LAP;
                        lap_val    <= cnt_val;
                        lap_active <= 1'b1;
                    end
                end
                LAP: begin
                    if (at_max || ss_p) begin
                        state      <= PAUSE;
                        cnt_go     <= 1'b0;
                        lap_active <= 1'b0;
                    end else if (lr_p) begin
                        state      <= RUN;
                        lap_active <= 1'b0;
                    end
                end
                PAUSE: begin
                    // At terminal count only lap/reset may leave PAUSE.
                    if (ss_p) begin
                        if (!at_max) begin
                            state  <= RUN;
                            cnt_go <= 1'b1;
                        end
                    end else if (lr_p) begin
                        state   <= IDLE;
                        cnt_clr <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt_go     <= 1'b0;
                    lap_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DEB_CYCLES=4: stimulus queues timed expectations, a monitor checks them.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       clr_n;
    logic       btn_ss;
    logic       btn_lr;
    logic [6:0] cnt_val;
    logic       cnt_go;
    logic       cnt_clr;
    logic [6:0] disp_val;
    logic       lap_active;
    logic [1:0] state_o;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_LAP   = 2'b11;

    stopwatch_ctrl #(.DEB_CYCLES(4), .CNT_MAX(99)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .btn_ss     (btn_ss),
        .btn_lr     (btn_lr),
        .cnt_val    (cnt_val),
        .cnt_go     (cnt_go),
        .cnt_clr    (cnt_clr),
        .disp_val   (disp_val),
        .lap_active (lap_active),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      name;
        logic [1:0] st;
        logic       go;
        logic       clr;
        logic [6:0] disp;
        logic       lap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic expect_st(input int dly, input string nm, input logic [1:0] st,
                             input logic go, input logic clr, input logic [6:0] disp,
                             input logic lap);
        exp_t e;
        e.at   = cyc + dly;
        e.name = nm;
        e.st   = st;
        e.go   = go;
        e.clr  = clr;
        e.disp = disp;
        e.lap  = lap;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic ss, input logic lr, input int hold);
        btn_ss = ss;
        btn_lr = lr;
        tick(hold);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        tick(8);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if ({state_o, cnt_go, cnt_clr, disp_val, lap_active} !==
                {e.st, e.go, e.clr, e.disp, e.lap}) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got st=%0d go=%0b clr=%0b disp=%0d lap=%0b, expected st=%0d go=%0b clr=%0b disp=%0d lap=%0b",
                         e.name, cyc, state_o, cnt_go, cnt_clr, disp_val, lap_active,
                         e.st, e.go, e.clr, e.disp, e.lap);
            end
        end
    end

    initial begin
        clr_n   = 1'b0;
        btn_ss  = 1'b0;
        btn_lr  = 1'b0;
        cnt_val = 7'd0;
        tick(3);
        expect_st(1, "reset_state", S_IDLE, 1'b0, 1'b0, 7'd0, 1'b0);
        tick(1);
        clr_n = 1'b1;
        tick(2);

        // Glitchy start/stop must never be accepted
        expect_st(10, "glitch_mid", S_IDLE, 1'b0, 1'b0, 7'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            btn_ss = 1'b1;
            tick(2);
            btn_ss = 1'b0;
            tick(2);
        end
        expect_st(8, "glitch_end", S_IDLE, 1'b0, 1'b0, 7'd0, 1'b0);
        tick(10);

        // Long start press gives exactly one event
        cnt_val = 7'd5;
        expect_st(6, "start_pre", S_IDLE, 1'b0, 1'b0, 7'd5, 1'b0);
        expect_st(7, "start_run", S_RUN, 1'b1, 1'b0, 7'd5, 1'b0);
        press(1'b1, 1'b0, 10);
        expect_st(1, "start_once", S_RUN, 1'b1, 1'b0, 7'd5, 1'b0);
        tick(2);

        // Lap capture and release
        cnt_val = 7'd37;
        expect_st(6, "lap_pre", S_RUN, 1'b1, 1'b0, 7'd37, 1'b0);
        expect_st(7, "lap_enter", S_LAP, 1'b1, 1'b0, 7'd37, 1'b1);
        press(1'b0, 1'b1, 8);
        cnt_val = 7'd41;
        expect_st(2, "lap_hold", S_LAP, 1'b1, 1'b0, 7'd37, 1'b1);
        expect_st(7, "lap_exit", S_RUN, 1'b1, 1'b0, 7'd37, 1'b0);
        expect_st(8, "lap_live", S_RUN, 1'b1, 1'b0, 7'd41, 1'b0);
        press(1'b0, 1'b1, 8);

        // Pause then clear
        expect_st(7, "pause", S_PAUSE, 1'b0, 1'b0, 7'd41, 1'b0);
        press(1'b1, 1'b0, 8);
        expect_st(6, "clr_pre", S_PAUSE, 1'b0, 1'b0, 7'd41, 1'b0);
        expect_st(7, "clr_pulse", S_IDLE, 1'b0, 1'b1, 7'd41, 1'b0);
        expect_st(8, "clr_one_clk", S_IDLE, 1'b0, 1'b0, 7'd41, 1'b0);
        press(1'b0, 1'b1, 8);

        // Simultaneous buttons: start/stop wins
        expect_st(7, "restart", S_RUN, 1'b1, 1'b0, 7'd41, 1'b0);
        press(1'b1, 1'b0, 8);
        expect_st(7, "both_pause", S_PAUSE, 1'b0, 1'b0, 7'd41, 1'b0);
        expect_st(8, "both_no_clr", S_PAUSE, 1'b0, 1'b0, 7'd41, 1'b0);
        press(1'b1, 1'b1, 8);

        // Terminal count behaviour
        expect_st(7, "resume", S_RUN, 1'b1, 1'b0, 7'd41, 1'b0);
        press(1'b1, 1'b0, 8);
        cnt_val = 7'd98;
        expect_st(1, "tc_98", S_RUN, 1'b1, 1'b0, 7'd98, 1'b0);
        tick(1);
        cnt_val = 7'd99;
`ifdef AUTO_STOP_EN
        expect_st(1, "tc_autostop", S_PAUSE, 1'b0, 1'b0, 7'd99, 1'b0);
        tick(1);
        expect_st(7, "tc_ss_ignored", S_PAUSE, 1'b0, 1'b0, 7'd99, 1'b0);
        press(1'b1, 1'b0, 8);
        expect_st(7, "tc_lr_clr", S_IDLE, 1'b0, 1'b1, 7'd99, 1'b0);
        expect_st(8, "tc_clr_end", S_IDLE, 1'b0, 1'b0, 7'd99, 1'b0);
        press(1'b0, 1'b1, 8);
        cnt_val = 7'd10;
        expect_st(7, "tc_restart", S_RUN, 1'b1, 1'b0, 7'd10, 1'b0);
        press(1'b1, 1'b0, 8);
`else
        expect_st(1, "tc_99", S_RUN, 1'b1, 1'b0, 7'd99, 1'b0);
        tick(1);
        cnt_val = 7'd0;
        expect_st(1, "tc_wrap", S_RUN, 1'b1, 1'b0, 7'd0, 1'b0);
        tick(1);
        cnt_val = 7'd10;
`endif

        // Asynchronous reset while in LAP
        expect_st(7, "lap2_enter", S_LAP, 1'b1, 1'b0, 7'd10, 1'b1);
        press(1'b0, 1'b1, 8);
        cnt_val = 7'd12;
        expect_st(1, "async_reset", S_IDLE, 1'b0, 1'b0, 7'd0, 1'b0);
        @(posedge clk);
        #2 clr_n = 1'b0;
        tick(1);
        expect_st(2, "reset_hold", S_IDLE, 1'b0, 1'b0, 7'd0, 1'b0);
        tick(3);
        clr_n = 1'b1;
        tick(3);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
